cmp_sort_ctrl: RTL and testbench

Sequencing controller that shares a single W-bit greater-than comparator to sort a block of N unsigned values in descending order. It sits between a valid/ready input stream and a valid/ready output stream. It loads N values, runs a fixed-length bubble sort using one compare per cycle, then drains the sorted block. It is the scheduler that time-multiplexes the team's one magnitude comparator across all element pairs.

---
 rtl/cmp_sort_pkg.sv | 20 ++
 rtl/nibble_gt.sv | 20 ++
 rtl/cmp_sort_ctrl.sv | 142 ++++++++++++++
 tb/tb_cmp_sort_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_sort_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cmp_sort_pkg                                                         |
// | Shared states and default sizes for the comparator-sharing sorter.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cmp_sort_pkg;

    localparam int DEF_W      = 4;
    localparam int DEF_N      = 8;
    localparam int SORT_STEPS = (DEF_N - 1) * (DEF_N - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/nibble_gt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nibble_gt                                                            |
// | Unsigned strict greater-than comparator (o_gt = i_a > i_b).          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module nibble_gt
    import cmp_sort_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_gt
);

    assign o_gt = (i_a > i_b);

endmodule
`default_nettype wire

// File: rtl/cmp_sort_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cmp_sort_ctrl                                                        |
// | Loads N values, bubble-sorts them descending through one shared      |
// | comparator (one compare per cycle), then drains the sorted block.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cmp_sort_ctrl
    import cmp_sort_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int N = DEF_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_in_valid,
    input  logic [W-1:0] i_in_data,
    output logic         o_in_ready,
    output logic         o_out_valid,
    output logic [W-1:0] o_out_data,
    output logic         o_out_last,
    input  logic         i_out_ready,
    output logic         o_busy
);

    localparam int            c_iw       = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_iw-1:0] c_last_idx = c_iw'(N - 1);
    localparam logic [c_iw-1:0] c_last_j   = c_iw'(N - 2);

    state_t            r_state;
    logic [W-1:0]      r_mem [N];
    logic [c_iw-1:0]   r_wr_idx;
    logic [c_iw-1:0]   r_pass;
    logic [c_iw-1:0]   r_j;
    logic [c_iw-1:0]   r_rd_idx;

    logic [c_iw-1:0]   w_j1;
    logic [c_iw-1:0]   w_rd_nxt;
    logic [W-1:0]      w_a;
    logic [W-1:0]      w_b;
    logic              w_gt;
    logic [W-1:0]      w_first_nxt;

    assign w_j1     = r_j + 1'b1;
    assign w_rd_nxt = r_rd_idx + 1'b1;
    assign w_a      = r_mem[w_j1];
    assign w_b      = r_mem[r_j];

    // The only comparator in the block; every pair is scheduled through it.
    nibble_gt #(
        .W (W)
    ) u_gt (
        .i_a  (w_a),
        .i_b  (w_b),
        .o_gt (w_gt)
    );

    // mem[0] as it will be after the current step, so the first drained beat
    // can be registered on the same edge as the final swap.
    assign w_first_nxt = (r_j == '0 && w_gt) ? w_a : r_mem[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_LOAD;
            r_wr_idx    <= '0;
            r_pass      <= '0;
            r_j         <= '0;
            r_rd_idx    <= '0;
            o_in_ready  <= 1'b1;
            o_out_valid <= 1'b0;
            o_out_data  <= '0;
            o_out_last  <= 1'b0;
            o_busy      <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (i_in_valid && o_in_ready) begin
                        r_mem[r_wr_idx] <= i_in_data;
                        if (r_wr_idx == c_last_idx) begin
                            r_state    <= ST_SORT;
                            r_wr_idx   <= '0;
                            r_pass     <= '0;
                            r_j        <= '0;
                            o_in_ready <= 1'b0;
                            o_busy     <= 1'b1;
                        end else begin
                            r_wr_idx <= r_wr_idx + 1'b1;
                        end
                    end
                end

                ST_SORT: begin
                    // Strict compare keeps equal values in place, so the sort is stable.
                    if (w_gt) begin
                        r_mem[r_j]  <= w_a;
                        r_mem[w_j1] <= w_b;
                    end
                    if (r_j == c_last_j) begin
                        r_j <= '0;
                        if (r_pass == c_last_j) begin
                            r_state     <= ST_DRAIN;
                            r_rd_idx    <= '0;
                            o_out_valid <= 1'b1;
                            o_out_data  <= w_first_nxt;
                            o_out_last  <= 1'b0;
                        end else begin
                            r_pass <= r_pass + 1'b1;
                        end
                    end else begin
                        r_j <= w_j1;
                    end
                end

                ST_DRAIN: begin
                    if (i_out_ready) begin
                        if (r_rd_idx == c_last_idx) begin
                            r_state     <= ST_LOAD;
                            r_rd_idx    <= '0;
                            o_out_valid <= 1'b0;
                            o_out_last  <= 1'b0;
                            o_busy      <= 1'b0;
                            o_in_ready  <= 1'b1;
                        end else begin
                            r_rd_idx   <= w_rd_nxt;
                            o_out_data <= r_mem[w_rd_nxt];
                            o_out_last <= (w_rd_nxt == c_last_idx);
                        end
                    end
                end

                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmp_sort_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cmp_sort_ctrl                                                     |
// | Scoreboard bench: stimulus pushes expected beats, monitor pops them. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_cmp_sort_ctrl;
    import cmp_sort_pkg::*;

    localparam int W = 4;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_in_valid = 1'b0;
    logic [W-1:0] i_in_data = '0;
    logic         o_in_ready;
    logic         o_out_valid;
    logic [W-1:0] o_out_data;
    logic         o_out_last;
    logic         i_out_ready = 1'b1;
    logic         o_busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int hs_count = 0;
    int last_hs_edge = -1;

    logic [W:0]   exp_q [$];
    logic [W:0]   mon_e;
    logic [W-1:0] prev_data = '0;
    logic         prev_last = 1'b0;
    logic         prev_stall = 1'b0;

    logic [W-1:0] blk [N];
    logic [W-1:0] srt [N];

    cmp_sort_ctrl #(
        .W (W),
        .N (N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (i_in_valid),
        .i_in_data   (i_in_data),
        .o_in_ready  (o_in_ready),
        .o_out_valid (o_out_valid),
        .o_out_data  (o_out_data),
        .o_out_last  (o_out_last),
        .i_out_ready (i_out_ready),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // Monitor: pops one expected beat per output handshake, checks stalls.
    always @(negedge clk) begin
        if (rst_n && o_out_valid) begin
            if (prev_stall) begin
                check("stall_data", int'(o_out_data), int'(prev_data));
                check("stall_last", int'(o_out_last), int'(prev_last));
            end
            if (i_out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", int'(o_out_data), int'(mon_e[W-1:0]));
                    check("out_last", int'(o_out_last), int'(mon_e[W]));
                end
                hs_count++;
                last_hs_edge = cyc + 1;
            end
        end
        prev_stall = rst_n && o_out_valid && !i_out_ready;
        prev_data  = o_out_data;
        prev_last  = o_out_last;
    end

    task automatic push_exp();
        for (int i = 0; i < N; i++) exp_q.push_back({(i == N - 1), srt[i]});
    endtask

    // Presents blk beat by beat; returns the edge number of the first accept.
    task automatic load_block(input bit hold_valid, output int first_edge);
        first_edge = -1;
        for (int i = 0; i < N; i++) begin
            int t = 0;
            i_in_valid = 1'b1;
            i_in_data  = blk[i];
            while (!o_in_ready && t < 400) begin
                @(posedge clk); #1; t++;
            end
            if (t >= 400) check("load_timeout", 0, 1);
            @(posedge clk); #1;
            if (i == 0) first_edge = cyc;
        end
        if (!hold_valid) i_in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int k, output int bad);
        k = 0; bad = 0;
        while (!o_out_valid && k < 200) begin
            if (!o_busy || o_in_ready) bad++;
            @(posedge clk); #1; k++;
        end
    endtask

    task automatic wait_idle(output int bad);
        int t = 0;
        bad = 0;
        while (!o_in_ready && t < 200) begin
            if (!o_busy) bad++;
            @(posedge clk); #1; t++;
        end
        check("idle_timeout", int'(t < 200), 1);
    endtask

    initial begin
        int k, bad, fe, hs0, cnt;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", int'(o_in_ready), 1);
        check("rst_out_valid", int'(o_out_valid), 0);
        check("rst_out_data", int'(o_out_data), 0);
        check("rst_busy", int'(o_busy), 0);
        rst_n = 1'b1;

        // Basic sort with latency check
        blk = '{3, 1, 4, 1, 5, 9, 2, 6};
        srt = '{9, 6, 5, 4, 3, 2, 1, 1};
        push_exp();
        load_block(1'b0, fe);
        check("busy_after_E0", int'(o_busy), 1);
        wait_valid(k, bad);
        check("latency", k, SORT_STEPS);
        wait_idle(bad);

        // Extremes, busy held through SORT and DRAIN
        blk = '{0, 15, 15, 0, 7, 15, 0, 7};
        srt = '{15, 15, 15, 7, 7, 0, 0, 0};
        push_exp();
        load_block(1'b0, fe);
        wait_valid(k, bad);
        check("busy_sort", bad, 0);
        wait_idle(bad);
        check("busy_drain", bad, 0);
        check("busy_low_idle", int'(o_busy), 0);

        // Backpressure
        blk = '{2, 8, 5, 11, 0, 14, 3, 9};
        srt = '{14, 11, 9, 8, 5, 3, 2, 0};
        push_exp();
        load_block(1'b0, fe);
        wait_valid(k, bad);
        hs0 = hs_count;
        cnt = 0;
        while (hs_count - hs0 < N && cnt < 100) begin
            i_out_ready = (cnt % 4 == 0) || (cnt % 4 == 3);
            @(posedge clk); #1; cnt++;
        end
        i_out_ready = 1'b1;
        wait_idle(bad);
        check("bp_handshakes", hs_count - hs0, N);
        check("bp_in_ready", int'(o_in_ready), 1);

        // Input gating: valid held high with changing data
        blk = '{10, 4, 12, 4, 1, 13, 7, 6};
        srt = '{13, 12, 10, 7, 6, 4, 4, 1};
        push_exp();
        load_block(1'b1, fe);
        cnt = 0;
        while (!o_in_ready && cnt < 200) begin
            i_in_data = W'(cyc);
            @(posedge clk); #1; cnt++;
        end
        i_in_valid = 1'b0;
        check("gate_ready_low_cycles", cnt, SORT_STEPS + N);

        // Reset in the middle of SORT
        blk = '{1, 9, 2, 8, 3, 7, 4, 6};
        load_block(1'b0, fe);
        repeat (19) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", int'(o_in_ready), 1);
        check("midrst_out_valid", int'(o_out_valid), 0);
        check("midrst_out_last", int'(o_out_last), 0);
        check("midrst_out_data", int'(o_out_data), 0);
        check("midrst_busy", int'(o_busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        blk = '{8, 7, 6, 5, 4, 3, 2, 1};
        srt = '{8, 7, 6, 5, 4, 3, 2, 1};
        push_exp();
        load_block(1'b0, fe);
        wait_valid(k, bad);
        check("post_rst_latency", k, SORT_STEPS);
        wait_idle(bad);

        // Back-to-back blocks
        blk = '{1, 2, 3, 4, 5, 6, 7, 8};
        srt = '{8, 7, 6, 5, 4, 3, 2, 1};
        push_exp();
        load_block(1'b1, fe);
        blk = '{5, 5, 3, 12, 9, 0, 15, 1};
        srt = '{15, 12, 9, 5, 5, 3, 1, 0};
        push_exp();
        load_block(1'b0, fe);
        check("b2b_first_accept", fe, last_hs_edge + 1);
        wait_valid(k, bad);
        wait_idle(bad);

        repeat (2) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
